exe_muldiv_unit: RTL and testbench

- Parametrised successor to the single-cycle execute ALU. Adds a multi-cycle multiply/divide unit with architectural HI/LO registers for MIPS mult, multu, div, divu, mthi and mtlo.
- Sits beside the combinational ALU in the execute stage.
- The controller raises op_valid and stalls the PC/fetch while busy is high. mfhi/mflo read hi/lo directly.

---
 rtl/exe_md_pkg.sv | 25 ++
 rtl/md_core.sv | 84 ++++++++
 rtl/exe_muldiv_unit.sv | 149 ++++++++++++++
 tb/tb_exe_muldiv_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_md_pkg.sv
// Shared op codes, FSM encoding and sizing helper for the execute-stage multiply/divide unit.
package exe_md_pkg;

    localparam int MD_MULT  = 0;
    localparam int MD_MULTU = 1;
    localparam int MD_DIV   = 2;
    localparam int MD_DIVU  = 3;
    localparam int MD_MTHI  = 4;
    localparam int MD_MTLO  = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } md_state_e;

    // Bits needed to count DATA_W-1 down to 0.
    function automatic int md_cnt_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/md_core.sv
// Unsigned iterative engine: radix-2 shift-add multiply and restoring divide sharing one adder.
module md_core
    import exe_md_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic                  is_div_i,
    input  logic [DATA_W-1:0]     a_i,
    input  logic [DATA_W-1:0]     b_i,
    output logic                  last_o,
    output logic [2*DATA_W-1:0]   res_o
);

    localparam int CNT_W = md_cnt_w(DATA_W);

    logic                 run_q, run_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 div_q;
    logic [DATA_W-1:0]    opd_q;
    logic [2*DATA_W-1:0]  acc_q, acc_step;
    logic [DATA_W:0]      add_x, add_y;
    logic                 add_cin;
    logic [DATA_W+1:0]    sum;
    logic                 ge;

    // Divide: acc = {remainder, dividend/quotient}; multiply: acc = {partial, multiplier}.
    always_comb begin
        if (div_q) begin
            add_x   = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
            add_y   = ~{1'b0, opd_q};
            add_cin = 1'b1;
        end else begin
            add_x   = {1'b0, acc_q[2*DATA_W-1:DATA_W]};
            add_y   = acc_q[0] ? {1'b0, opd_q} : '0;
            add_cin = 1'b0;
        end
        sum = {1'b0, add_x} + {1'b0, add_y} + {{(DATA_W+1){1'b0}}, add_cin};
        ge  = sum[DATA_W+1];
        if (div_q)
            acc_step = {(ge ? sum[DATA_W-1:0] : add_x[DATA_W-1:0]), acc_q[DATA_W-2:0], ge};
        else
            acc_step = {sum[DATA_W:0], acc_q[DATA_W-1:1]};
    end

    always_comb begin
        run_d = run_q;
        cnt_d = cnt_q;
        if (start_i) begin
            run_d = 1'b1;
            cnt_d = CNT_W'(DATA_W-1);
        end else if (run_q) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (abort_i || cnt_q == '0) run_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            run_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            run_q <= run_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (start_i) begin
            acc_q <= {{DATA_W{1'b0}}, (is_div_i ? a_i : b_i)};
            opd_q <= is_div_i ? b_i : a_i;
            div_q <= is_div_i;
        end else if (run_q) begin
            acc_q <= acc_step;
        end
    end

    assign last_o = run_q && (cnt_q == '0);
    assign res_o  = acc_q;

endmodule

// File: rtl/exe_muldiv_unit.sv
// Execute-stage multiply/divide unit with architectural HI/LO; sign handling lives here, magnitudes in md_core.
module exe_muldiv_unit
    import exe_md_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OPC_W  = 3
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               op_valid,
    output logic               op_ready,
    input  logic [OPC_W-1:0]   op_code,
    input  logic [DATA_W-1:0]  src_a,
    input  logic [DATA_W-1:0]  src_b,
    input  logic               flush,
    output logic               busy,
    output logic               done,
    output logic               div_zero,
    output logic [DATA_W-1:0]  hi,
    output logic [DATA_W-1:0]  lo
);

    md_state_e            state_q, state_d;
    logic [DATA_W-1:0]    hi_q, hi_d, lo_q, lo_d;
    logic                 done_q, done_d, dz_q, dz_d;
    logic                 sgn_quo_q, sgn_rem_q, div_q;
    logic                 is_mul, is_div, is_sgn, is_mthi, is_mtlo, b_zero, accept;
    logic                 start, abort, core_last;
    logic [2*DATA_W-1:0]  core_res, prod;
    logic [DATA_W-1:0]    fix_hi, fix_lo;

    function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] v, input logic en);
        return (en && v < 0) ? DATA_W'(-v) : DATA_W'(v);
    endfunction

    function automatic logic [DATA_W-1:0] neg_w(input logic [DATA_W-1:0] v, input logic en);
        return en ? (~v + DATA_W'(1)) : v;
    endfunction

    function automatic logic [2*DATA_W-1:0] neg_d(input logic [2*DATA_W-1:0] v, input logic en);
        return en ? (~v + (2*DATA_W)'(1)) : v;
    endfunction

    assign is_mul  = (op_code == OPC_W'(MD_MULT)) || (op_code == OPC_W'(MD_MULTU));
    assign is_div  = (op_code == OPC_W'(MD_DIV))  || (op_code == OPC_W'(MD_DIVU));
    assign is_sgn  = (op_code == OPC_W'(MD_MULT)) || (op_code == OPC_W'(MD_DIV));
    assign is_mthi = (op_code == OPC_W'(MD_MTHI));
    assign is_mtlo = (op_code == OPC_W'(MD_MTLO));
    assign b_zero  = (src_b == '0);
    assign accept  = op_valid && (state_q == S_IDLE) && !flush;

    md_core #(.DATA_W(DATA_W)) u_core (
        .clock    (clock),
        .reset_n  (reset_n),
        .start_i  (start),
        .abort_i  (abort),
        .is_div_i (is_div),
        .a_i      (mag(src_a, is_sgn)),
        .b_i      (mag(src_b, is_sgn)),
        .last_o   (core_last),
        .res_o    (core_res)
    );

    // Core returns {rem, quo} for divide and the full product for multiply.
    always_comb begin
        prod   = neg_d(core_res, sgn_quo_q);
        fix_hi = div_q ? neg_w(core_res[2*DATA_W-1:DATA_W], sgn_rem_q) : prod[2*DATA_W-1:DATA_W];
        fix_lo = div_q ? neg_w(core_res[DATA_W-1:0], sgn_quo_q) : prod[DATA_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dz_d    = dz_q;
        start   = 1'b0;
        abort   = 1'b0;
        case (state_q)
            S_IDLE: if (accept) begin
                dz_d = 1'b0;
                if (is_mthi) begin
                    hi_d   = src_a;
                    done_d = 1'b1;
                end else if (is_mtlo) begin
                    lo_d   = src_a;
                    done_d = 1'b1;
                end else if (is_div && b_zero) begin
                    hi_d   = src_a;
                    lo_d   = '1;
                    done_d = 1'b1;
                    dz_d   = 1'b1;
                end else if (is_mul || is_div) begin
                    start   = 1'b1;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (flush) begin
                    abort   = 1'b1;
                    state_d = S_IDLE;
                end else if (core_last) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!flush) begin
                    hi_d   = fix_hi;
                    lo_d   = fix_lo;
                    done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    always_ff @(posedge clock) begin
        if (start) begin
            sgn_quo_q <= is_sgn && (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
            sgn_rem_q <= is_sgn && src_a[DATA_W-1];
            div_q     <= is_div;
        end
    end

    assign op_ready = reset_n && (state_q == S_IDLE);
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Randomized and directed bench for exe_muldiv_unit against an arithmetic reference model.
module tb_exe_muldiv_unit;

    localparam int W = 32;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          op_valid, op_ready, flush, busy, done, div_zero;
    logic [2:0]    op_code;
    logic [W-1:0]  src_a, src_b, hi, lo;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0]  m_hi, m_lo;
    logic          m_dz, m_done, m_iter;

    exe_muldiv_unit #(.DATA_W(W), .OPC_W(3)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_code  (op_code),
        .src_a    (src_a),
        .src_b    (src_b),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog timeout n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    // Architectural reference: plain 64-bit arithmetic on the instruction semantics.
    task automatic model_apply(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        m_done = 1'b1;
        m_iter = 1'b0;
        m_dz   = 1'b0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; m_iter = 1'b1; end
            3'd1: begin p = {32'h0, a} * {32'h0, b}; m_hi = p[63:32]; m_lo = p[31:0]; m_iter = 1'b1; end
            3'd2, 3'd3: begin
                if (b == 0) begin
                    m_hi = a; m_lo = '1; m_dz = 1'b1;
                end else begin
                    if (op == 3'd3) begin sa = longint'({32'h0, a}); sb = longint'({32'h0, b}); end
                    q = sa / sb;
                    r = sa % sb;
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                    m_iter = 1'b1;
                end
            end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: m_done = 1'b0;
        endcase
    endtask

    // Issue one op, scramble operands after accept, then watch for done (bounded).
    task automatic exec(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int maxk,
                        output int k, output int bc, output bit seen, output logic d2);
        @(negedge clock);
        op_valid = 1'b1; op_code = op; src_a = a; src_b = b;
        @(negedge clock);
        op_valid = 1'b0; op_code = 3'($urandom); src_a = $urandom; src_b = $urandom;
        k = 0; bc = 0; seen = 1'b0; d2 = 1'b0;
        while (k <= maxk) begin
            if (done) begin seen = 1'b1; break; end
            bc += int'(busy);
            @(negedge clock);
            k++;
        end
        if (seen) begin
            @(negedge clock);
            d2 = done;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; op_valid = 1'b0; flush = 1'b0; op_code = '0; src_a = '0; src_b = '0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        m_hi = '0; m_lo = '0; m_dz = 1'b0;
        n_cmp++; if (hi !== 0)       begin n_bad++; $display("FAIL reset_hi got=%h exp=0", hi); end
        n_cmp++; if (lo !== 0)       begin n_bad++; $display("FAIL reset_lo got=%h exp=0", lo); end
        n_cmp++; if (busy !== 0)     begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (done !== 0)     begin n_bad++; $display("FAIL reset_done got=%b exp=0", done); end
        n_cmp++; if (div_zero !== 0) begin n_bad++; $display("FAIL reset_dz got=%b exp=0", div_zero); end
        n_cmp++; if (op_ready !== 1) begin n_bad++; $display("FAIL reset_ready got=%b exp=1", op_ready); end
    endtask

    task automatic test_directed();
        logic [2:0]   t_op[9] = '{3'd0, 3'd2, 3'd3, 3'd2, 3'd1, 3'd2, 3'd1, 3'd4, 3'd6};
        logic [W-1:0] t_a[9]  = '{32'd7, 32'hFFFFFFF9, 32'd100, 32'h12345678, 32'd3, 32'h80000000,
                                  32'hFFFFFFFF, 32'hCAFEF00D, 32'h0BADBEEF};
        logic [W-1:0] t_b[9]  = '{32'hFFFFFFFD, 32'd2, 32'd7, 32'd0, 32'd5, 32'hFFFFFFFF,
                                  32'hFFFFFFFF, 32'd9, 32'd3};
        int k, bc;
        bit seen;
        logic d2;
        for (int i = 0; i < 9; i++) begin
            model_apply(t_op[i], t_a[i], t_b[i]);
            exec(t_op[i], t_a[i], t_b[i], m_done ? 40 : 3, k, bc, seen, d2);
            n_cmp++; if (seen !== m_done) begin n_bad++; $display("FAIL dir%0d_done_seen got=%b exp=%b", i, seen, m_done); end
            if (m_done) begin
                n_cmp++;
                if (m_iter ? (k != W+1) : (m_dz ? (k > 1) : (k != 0))) begin
                    n_bad++; $display("FAIL dir%0d_latency got=%0d iter=%b", i, k, m_iter);
                end
                n_cmp++; if (d2 !== 1'b0) begin n_bad++; $display("FAIL dir%0d_done_width got=%b exp=0", i, d2); end
            end
            n_cmp++; if (bc != (m_iter ? W+1 : 0)) begin n_bad++; $display("FAIL dir%0d_busy_cycles got=%0d exp=%0d", i, bc, m_iter ? W+1 : 0); end
            n_cmp++; if (hi !== m_hi) begin n_bad++; $display("FAIL dir%0d_hi got=%h exp=%h", i, hi, m_hi); end
            n_cmp++; if (lo !== m_lo) begin n_bad++; $display("FAIL dir%0d_lo got=%h exp=%h", i, lo, m_lo); end
            n_cmp++; if (div_zero !== m_dz) begin n_bad++; $display("FAIL dir%0d_div_zero got=%b exp=%b", i, div_zero, m_dz); end
        end
    endtask

    task automatic test_random();
        logic [2:0] op;
        logic [W-1:0] a, b;
        int r, sel, k, bc;
        bit seen;
        logic d2;
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 15);
            op = (r < 12) ? 3'(r % 4) : ((r < 14) ? 3'(4 + r % 2) : 3'(6 + r % 2));
            a = $urandom; b = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) b = '0;
            else if (sel == 1) b = 32'($urandom_range(1, 15));
            else if (sel == 2) a = 32'h80000000;
            else if (sel == 3) b = 32'hFFFFFFFF;
            model_apply(op, a, b);
            exec(op, a, b, m_done ? 40 : 3, k, bc, seen, d2);
            n_cmp++; if (seen !== m_done) begin n_bad++; $display("FAIL rnd%0d_done_seen op=%0d got=%b exp=%b", i, op, seen, m_done); end
            n_cmp++; if (bc != (m_iter ? W+1 : 0)) begin n_bad++; $display("FAIL rnd%0d_busy_cycles got=%0d exp=%0d", i, bc, m_iter ? W+1 : 0); end
            n_cmp++; if (hi !== m_hi) begin n_bad++; $display("FAIL rnd%0d_hi op=%0d a=%h b=%h got=%h exp=%h", i, op, a, b, hi, m_hi); end
            n_cmp++; if (lo !== m_lo) begin n_bad++; $display("FAIL rnd%0d_lo op=%0d a=%h b=%h got=%h exp=%h", i, op, a, b, lo, m_lo); end
            n_cmp++; if (div_zero !== m_dz) begin n_bad++; $display("FAIL rnd%0d_div_zero got=%b exp=%b", i, div_zero, m_dz); end
        end
    endtask

    task automatic test_flush();
        int k, bc, dn;
        bit seen;
        logic d2;
        model_apply(3'd4, 32'hA5A5A5A5, 32'd0);
        exec(3'd4, 32'hA5A5A5A5, 32'd0, 40, k, bc, seen, d2);
        n_cmp++; if (hi !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL flush_mthi got=%h exp=a5a5a5a5", hi); end
        // MULT 2*3, MTLO request held high while busy, flush in the tenth CALC cycle
        dn = 0;
        @(negedge clock);
        op_valid = 1'b1; op_code = 3'd0; src_a = 32'd2; src_b = 32'd3;
        @(negedge clock);
        op_code = 3'd5; src_a = 32'hDEAD0000;
        repeat (9) begin dn += int'(done); @(negedge clock); end
        op_valid = 1'b0; flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL flush_calc_busy got=%b exp=0", busy); end
        n_cmp++; if (op_ready !== 1'b1) begin n_bad++; $display("FAIL flush_calc_ready got=%b exp=1", op_ready); end
        repeat (40) begin dn += int'(done); @(negedge clock); end
        n_cmp++; if (dn != 0) begin n_bad++; $display("FAIL flush_calc_done got=%0d exp=0", dn); end
        n_cmp++; if (hi !== m_hi) begin n_bad++; $display("FAIL flush_calc_hi got=%h exp=%h", hi, m_hi); end
        n_cmp++; if (lo !== m_lo) begin n_bad++; $display("FAIL flush_calc_lo got=%h exp=%h", lo, m_lo); end
        // MULTU 5*5 flushed in FIX
        dn = 0;
        @(negedge clock);
        op_valid = 1'b1; op_code = 3'd1; src_a = 32'd5; src_b = 32'd5;
        @(negedge clock);
        op_valid = 1'b0;
        repeat (W) begin dn += int'(done); @(negedge clock); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL flush_fix_busy_before got=%b exp=1", busy); end
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_fix_busy_after got=%b exp=0", busy); end
        repeat (5) begin dn += int'(done); @(negedge clock); end
        n_cmp++; if (dn != 0) begin n_bad++; $display("FAIL flush_fix_done got=%0d exp=0", dn); end
        n_cmp++; if (lo !== m_lo) begin n_bad++; $display("FAIL flush_fix_lo got=%h exp=%h", lo, m_lo); end
        // flush while idle blocks an MTHI request
        @(negedge clock);
        op_valid = 1'b1; op_code = 3'd4; src_a = 32'h11111111; flush = 1'b1;
        @(negedge clock);
        op_valid = 1'b0; flush = 1'b0;
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL flush_idle_done got=%b exp=0", done); end
        n_cmp++; if (hi !== m_hi)   begin n_bad++; $display("FAIL flush_idle_hi got=%h exp=%h", hi, m_hi); end
    endtask

    task automatic test_async_reset();
        int k, bc;
        bit seen;
        logic d2;
        model_apply(3'd5, 32'h5555AAAA, 32'd0);
        exec(3'd5, 32'h5555AAAA, 32'd0, 40, k, bc, seen, d2);
        @(negedge clock);
        op_valid = 1'b1; op_code = 3'd0; src_a = 32'd9; src_b = 32'd9;
        @(negedge clock);
        op_valid = 1'b0;
        repeat (5) @(negedge clock);
        reset_n = 1'b0;
        #1;
        m_hi = '0; m_lo = '0; m_dz = 1'b0;
        n_cmp++; if (hi !== 0)       begin n_bad++; $display("FAIL arst_hi got=%h exp=0", hi); end
        n_cmp++; if (lo !== 0)       begin n_bad++; $display("FAIL arst_lo got=%h exp=0", lo); end
        n_cmp++; if (busy !== 0)     begin n_bad++; $display("FAIL arst_busy got=%b exp=0", busy); end
        n_cmp++; if (done !== 0)     begin n_bad++; $display("FAIL arst_done got=%b exp=0", done); end
        n_cmp++; if (div_zero !== 0) begin n_bad++; $display("FAIL arst_dz got=%b exp=0", div_zero); end
        @(negedge clock);
        reset_n = 1'b1;
        model_apply(3'd0, 32'd4, 32'd4);
        exec(3'd0, 32'd4, 32'd4, 40, k, bc, seen, d2);
        n_cmp++; if (seen !== 1'b1)  begin n_bad++; $display("FAIL arst_mult_done got=%b exp=1", seen); end
        n_cmp++; if (lo !== 32'd16)  begin n_bad++; $display("FAIL arst_mult_lo got=%h exp=10", lo); end
        n_cmp++; if (hi !== m_hi)    begin n_bad++; $display("FAIL arst_mult_hi got=%h exp=%h", hi, m_hi); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
